// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB master port between NUM_REQ requesters,
// with peripheral decode, SETUP/ACCESS sequencing, wait states and a wait timeout.
module apb_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [32*NUM_REQ-1:0] req_addr,
  input  logic [32*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic                  err,
  output logic [31:0]           rdata,
  output logic [31:0]           paddr,
  output logic [31:0]           pwdata,
  output logic                  pwrite,
  output logic [2:0]            pselx,
  output logic                  penable,
  input  logic [31:0]           prdata,
  input  logic                  pready,
  input  logic                  pslverr
);
  localparam int IDX_W  = 2;
  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Three 64 MB windows starting at 0x8000_0000; anything else is a miss.
  function automatic logic [2:0] decode_sel(input logic [31:0] addr);
    logic [2:0] sel;
    case (addr[31:26])
      6'b100000: sel = 3'b001;
      6'b100001: sel = 3'b010;
      6'b100010: sel = 3'b100;
      default:   sel = 3'b000;
    endcase
    return sel;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    for (int j = 0; j < NUM_REQ; j++) begin
      vec[j] = (idx == IDX_W'(j));
    end
    return vec;
  endfunction

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   ptr_r, ptr_s, owner_r, owner_s;
  logic [WAIT_W-1:0]  wait_r, wait_s, wait_inc_s;
  logic [2:0]         sel_r, sel_s, pselx_r, pselx_s, win_sel_s;
  logic [31:0]        paddr_r, paddr_s, pwdata_r, pwdata_s, rdata_r, rdata_s;
  logic               pwrite_r, pwrite_s, penable_r, penable_s, err_r, err_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_s, done_r, done_s;
  logic               win_found_s, win_write_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic [31:0]        win_addr_s, win_wdata_s;

  assign win_sel_s  = decode_sel(win_addr_s);
  assign wait_inc_s = wait_r + WAIT_W'(1);

  // Round-robin pick: the requester closest to ptr_r (going upward, wrapping) wins
  always_comb begin
    int best;
    best        = NUM_REQ;
    win_found_s = 1'b0;
    win_idx_s   = ptr_r;
    win_write_s = 1'b0;
    win_addr_s  = 32'h0000_0000;
    win_wdata_s = 32'h0000_0000;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req[j] && (((j + NUM_REQ - int'(ptr_r)) % NUM_REQ) < best)) begin
        best        = (j + NUM_REQ - int'(ptr_r)) % NUM_REQ;
        win_found_s = 1'b1;
        win_idx_s   = IDX_W'(j);
        win_write_s = req_write[j];
        win_addr_s  = req_addr[32*j +: 32];
        win_wdata_s = req_wdata[32*j +: 32];
      end else begin
        best = best;
      end
    end
  end

  // Next-state and next-output logic; every output is registered from here
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    owner_s   = owner_r;
    wait_s    = wait_r;
    sel_s     = sel_r;
    paddr_s   = paddr_r;
    pwdata_s  = pwdata_r;
    pwrite_s  = pwrite_r;
    rdata_s   = rdata_r;
    gnt_s     = gnt_r;
    pselx_s   = 3'b000;
    penable_s = 1'b0;
    done_s    = {NUM_REQ{1'b0}};
    err_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (win_found_s) begin
          owner_s = win_idx_s;
          gnt_s   = onehot(win_idx_s);
          if (win_sel_s != 3'b000) begin
            state_s  = S_SETUP;
            sel_s    = win_sel_s;
            pselx_s  = win_sel_s;
            paddr_s  = win_addr_s;
            pwdata_s = win_wdata_s;
            pwrite_s = win_write_s;
          end else begin
            // Decode miss completes immediately without touching the bus
            state_s = S_DONE;
            done_s  = onehot(win_idx_s);
            err_s   = 1'b1;
          end
        end else begin
          gnt_s = {NUM_REQ{1'b0}};
        end
      end
      S_SETUP: begin
        state_s   = S_ACCESS;
        pselx_s   = sel_r;
        penable_s = 1'b1;
        wait_s    = {WAIT_W{1'b0}};
      end
      S_ACCESS: begin
        if (pready) begin
          state_s = S_DONE;
          done_s  = onehot(owner_r);
          err_s   = pslverr;
          if (!pwrite_r) begin
            rdata_s = prdata;
          end else begin
            rdata_s = rdata_r;
          end
        end else if ((TIMEOUT != 0) && (wait_inc_s == WAIT_W'(TIMEOUT))) begin
          state_s = S_DONE;
          done_s  = onehot(owner_r);
          err_s   = 1'b1;
        end else begin
          pselx_s   = sel_r;
          penable_s = 1'b1;
          wait_s    = wait_inc_s;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
        gnt_s   = {NUM_REQ{1'b0}};
        ptr_s   = (owner_r == IDX_W'(NUM_REQ - 1)) ? IDX_W'(0) : owner_r + IDX_W'(1);
      end
      default: begin
        state_s = S_IDLE;
        gnt_s   = {NUM_REQ{1'b0}};
      end
    endcase
  end

  // State, pointer and output registers with synchronous active-high reset
  always_ff @(posedge hclk) begin
    if (hresetn) begin
      state_r   <= S_IDLE;
      ptr_r     <= {IDX_W{1'b0}};
      owner_r   <= {IDX_W{1'b0}};
      wait_r    <= {WAIT_W{1'b0}};
      sel_r     <= 3'b000;
      paddr_r   <= 32'h0000_0000;
      pwdata_r  <= 32'h0000_0000;
      pwrite_r  <= 1'b0;
      rdata_r   <= 32'h0000_0000;
      gnt_r     <= {NUM_REQ{1'b0}};
      pselx_r   <= 3'b000;
      penable_r <= 1'b0;
      done_r    <= {NUM_REQ{1'b0}};
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      owner_r   <= owner_s;
      wait_r    <= wait_s;
      sel_r     <= sel_s;
      paddr_r   <= paddr_s;
      pwdata_r  <= pwdata_s;
      pwrite_r  <= pwrite_s;
      rdata_r   <= rdata_s;
      gnt_r     <= gnt_s;
      pselx_r   <= pselx_s;
      penable_r <= penable_s;
      done_r    <= done_s;
      err_r     <= err_s;
    end
  end

  assign gnt     = gnt_r;
  assign done    = done_r;
  assign err     = err_r;
  assign rdata   = rdata_r;
  assign paddr   = paddr_r;
  assign pwdata  = pwdata_r;
  assign pwrite  = pwrite_r;
  assign pselx   = pselx_r;
  assign penable = penable_r;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed steps then random transfers, checked against
// a transaction-level model (round-robin scan, window decode, latency arithmetic).
module tb_apb_req_arbiter;
  localparam int N = 3;
  localparam int T = 16;

  logic            hclk = 1'b0;
  logic            hresetn;
  logic [N-1:0]    req, req_write, gnt, done;
  logic [32*N-1:0] req_addr, req_wdata;
  logic            err, pwrite, penable, pready, pslverr;
  logic [31:0]     rdata, paddr, pwdata, prdata;
  logic [2:0]      pselx;

  int          n_vec = 0;
  int          n_mis = 0;
  int          m_ptr;
  logic [31:0] m_rdata, m_paddr, m_pwdata;
  logic        m_pwrite;
  int          w;

  always #5 hclk = ~hclk;

  apb_req_arbiter #(.NUM_REQ(N), .TIMEOUT(T)) dut (
    .hclk(hclk), .hresetn(hresetn), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .err(err), .rdata(rdata), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .pselx(pselx), .penable(penable), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  function automatic logic [2:0] exp_sel(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a <= 32'h83FF_FFFF) return 3'b001;
    else if (a >= 32'h8400_0000 && a <= 32'h87FF_FFFF) return 3'b010;
    else if (a >= 32'h8800_0000 && a <= 32'h8BFF_FFFF) return 3'b100;
    else return 3'b000;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000 + ($urandom & 32'h03FF_FFFF);
      1:       return 32'h8400_0000 + ($urandom & 32'h03FF_FFFF);
      2:       return 32'h8800_0000 + ($urandom & 32'h03FF_FFFF);
      3:       return 32'h8C00_0000 + ($urandom & 32'h33FF_FFFF);
      default: return $urandom & 32'h7FFF_FFFF;
    endcase
  endfunction

  task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    req[i]                = 1'b1;
    req_write[i]          = wr;
    req_addr[32*i +: 32]  = a;
    req_wdata[32*i +: 32] = d;
  endtask

  task automatic check_reset_vals();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_pselx", 32'(pselx), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
  endtask

  // Called in the IDLE cycle where req is sampled; returns one cycle after DONE.
  task automatic do_round(input int waits, input logic slverr, input logic [31:0] rd_val,
                          output int win);
    int          d;
    logic [2:0]  sel;
    logic [N-1:0] oh;
    logic        exp_err, is_wr;
    logic [31:0] addr, wdata;
    win = -1;
    for (int k = 0; k < N; k++) begin
      if (win < 0 && req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    end
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_pselx", 32'(pselx), 32'd0);
    chk("idle_penable", 32'(penable), 32'd0);
    chk("idle_rdata", rdata, m_rdata);
    chk("idle_paddr", paddr, m_paddr);
    pready  = 1'($urandom);
    pslverr = 1'($urandom);
    prdata  = $urandom;
    if (win < 0) begin
      step();
      return;
    end
    is_wr = req_write[win];
    addr  = req_addr[32*win +: 32];
    wdata = req_wdata[32*win +: 32];
    sel   = exp_sel(addr);
    oh    = '0;
    oh[win] = 1'b1;
    if (sel == 3'b000) begin
      d = 1; exp_err = 1'b1;
    end else if (waits < T) begin
      d = 3 + waits; exp_err = slverr;
    end else begin
      d = 2 + T; exp_err = 1'b1;
    end
    if (sel != 3'b000) begin
      m_paddr = addr; m_pwrite = is_wr; m_pwdata = wdata;
    end
    for (int c = 1; c <= d; c++) begin
      step();
      chk("gnt", 32'(gnt), 32'(oh));
      if (c < d) begin
        chk("pselx", 32'(pselx), 32'(sel));
        chk("penable", 32'(penable), (c >= 2) ? 32'd1 : 32'd0);
        chk("done_early", 32'(done), 32'd0);
        if (c == 1) begin
          chk("paddr", paddr, m_paddr);
          chk("pwrite", 32'(pwrite), 32'(m_pwrite));
          chk("pwdata", pwdata, m_pwdata);
        end
      end else begin
        if (sel != 3'b000 && waits < T && !is_wr) m_rdata = rd_val;
        chk("done", 32'(done), 32'(oh));
        chk("err", 32'(err), 32'(exp_err));
        chk("rdata", rdata, m_rdata);
        chk("done_pselx", 32'(pselx), 32'd0);
        chk("done_penable", 32'(penable), 32'd0);
      end
      if (c >= 2 && c < d) begin
        pready  = (c >= 2 + waits);
        prdata  = pready ? rd_val : $urandom;
        pslverr = pready ? slverr : 1'($urandom);
      end else begin
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
      end
    end
    m_ptr = (win + 1) % N;
    step();
  endtask

  initial begin
    logic [31:0] bnd [5];
    int          last_win, wt, u;
    hresetn = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
    m_ptr = 0; m_rdata = 32'h0; m_paddr = 32'h0; m_pwdata = 32'h0; m_pwrite = 1'b0;
    step(); step();
    check_reset_vals();
    hresetn = 1'b0;

    // Directed transfers
    set_req(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF); do_round(0, 1'b0, 32'h0, w); req[0] = 1'b0;
    set_req(1, 1'b0, 32'h8400_0004, 32'h0);         do_round(3, 1'b0, 32'h1234_5678, w); req[1] = 1'b0;
    set_req(0, 1'b1, 32'h8800_0000, 32'h0000_0001); do_round(0, 1'b1, 32'h0, w); req[0] = 1'b0;
    set_req(1, 1'b0, 32'h9000_0000, 32'h0);         do_round(0, 1'b0, 32'h5555_AAAA, w); req[1] = 1'b0;
    set_req(0, 1'b0, 32'h8000_0100, 32'h0);         do_round(T + 4, 1'b0, 32'hBAD0_BAD0, w); req[0] = 1'b0;
    set_req(2, 1'b0, 32'h8800_1000, 32'h0);         do_round(T - 1, 1'b0, 32'hCAFE_F00D, w); req[2] = 1'b0;
    bnd[0] = 32'h83FF_FFFC; bnd[1] = 32'h8400_0000; bnd[2] = 32'h8BFF_FFFC;
    bnd[3] = 32'h8C00_0000; bnd[4] = 32'h7FFF_FFFC;
    for (int b = 0; b < 5; b++) begin
      set_req(0, 1'b0, bnd[b], 32'h0);
      do_round(1, 1'b0, 32'hA000_0000 + 32'(b), w);
      req[0] = 1'b0;
    end

    // Reset during an ACCESS wait state
    set_req(0, 1'b0, 32'h8000_0040, 32'h0);
    pready = 1'b0;
    step(); step(); step();
    hresetn = 1'b1;
    step();
    check_reset_vals();
    hresetn = 1'b0;
    m_ptr = 0; m_rdata = 32'h0; m_paddr = 32'h0; m_pwdata = 32'h0; m_pwrite = 1'b0;

    // Two held requesters alternate
    set_req(0, 1'b0, 32'h8000_0200, 32'h0);
    set_req(1, 1'b1, 32'h8400_0300, 32'h1111_2222);
    for (int r = 0; r < 4; r++) begin
      do_round(r % 2, 1'b0, $urandom, w);
      set_req(w, 1'($urandom), rand_addr(), $urandom);
    end
    req = '0;

    // Random traffic
    last_win = -1;
    for (int r = 0; r < 80; r++) begin
      for (int i = 0; i < N; i++) begin
        if (i == last_win) begin
          if ($urandom_range(0, 2) != 0) set_req(i, 1'($urandom), rand_addr(), $urandom);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, 1'($urandom), rand_addr(), $urandom);
        end
      end
      u = $urandom_range(0, 9);
      if (u < 6)       wt = $urandom_range(0, 3);
      else if (u == 6) wt = $urandom_range(4, 8);
      else if (u == 7) wt = T - 1;
      else             wt = T + $urandom_range(0, 3);
      do_round(wt, 1'($urandom_range(0, 3) == 0), $urandom, last_win);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
